seq_alu: RTL and testbench

//  Multi-cycle, parametrised successor to the 8-bit datapath ALU. Accepts one operation per

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 199 +++++++++++++++++++
 tb/tb_seq_alu.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for the multi-cycle ALU.
// master drives operations and consumes results; slave is the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       operation;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ZERO;
    logic             NEG;
    logic             CARRY;
    logic             OVF;

    modport master (
        output in_valid, op1, op2, operation, is_signed, out_ready,
        input  in_ready, out_valid, result, ZERO, NEG, CARRY, OVF
    );

    modport slave (
        input  in_valid, op1, op2, operation, is_signed, out_ready,
        output in_ready, out_valid, result, ZERO, NEG, CARRY, OVF
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith, iterative shifts,
// shift-add multiply; result and flags held until consumed.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MUL = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_ORR = 3'd4;
    localparam logic [2:0] OP_LSL = 3'd5;
    localparam logic [2:0] OP_LSR = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] asr;
    logic [WIDTH-1:0] step;
    logic [SHW-1:0]   amt;
    logic             sa;
    logic             sb;
    logic             load;

    assign sum  = {1'b0, bus.op1} + {1'b0, bus.op2};
    assign diff = {1'b0, bus.op1} - {1'b0, bus.op2};
    assign sa   = bus.op1[WIDTH-1];
    assign sb   = bus.op2[WIDTH-1];

    // Shift distance saturates at WIDTH: further steps change nothing.
    assign amt = (bus.op2 >= WIDTH'(WIDTH)) ? SHW'(WIDTH)
                                            : bus.op2[SHW-1:0];

    assign acc_step = acc_q + (b_q[0] ? a_q : '0);
    assign shl      = a_q << 1;
    assign shr      = a_q >> 1;
    assign asr      = {a_q[WIDTH-1], a_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        step    = a_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.operation;
                    a_d     = bus.op1;
                    b_d     = bus.op2;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                    unique case (bus.operation)
                        OP_ADD: begin
                            res_d   = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                            ovf_d   = bus.is_signed & (sa == sb)
                                    & (sum[WIDTH-1] != sa);
                            load    = 1'b1;
                        end
                        OP_SUB: begin
                            res_d   = diff[WIDTH-1:0];
                            carry_d = ~diff[WIDTH];
                            ovf_d   = bus.is_signed & (sa != sb)
                                    & (diff[WIDTH-1] != sa);
                            load    = 1'b1;
                        end
                        OP_AND: begin
                            res_d = bus.op1 & bus.op2;
                            load  = 1'b1;
                        end
                        OP_ORR: begin
                            res_d = bus.op1 | bus.op2;
                            load  = 1'b1;
                        end
                        OP_MUL: begin
                            cnt_d   = SHW'(WIDTH);
                            state_d = EXEC;
                        end
                        default: begin
                            if (amt == '0) begin
                                res_d = bus.op1;
                                load  = 1'b1;
                            end else begin
                                cnt_d   = amt;
                                state_d = EXEC;
                            end
                        end
                    endcase
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                unique case (op_q)
                    OP_MUL: begin
                        acc_d = acc_step;
                        a_d   = shl;
                        b_d   = b_q >> 1;
                        step  = acc_step;
                    end
                    OP_LSL: begin
                        a_d  = shl;
                        step = shl;
                    end
                    OP_LSR: begin
                        a_d  = shr;
                        step = shr;
                    end
                    default: begin
                        a_d  = asr;
                        step = asr;
                    end
                endcase
                if (cnt_q == SHW'(1)) begin
                    res_d   = step;
                    load    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            zero_d = (res_d == '0);
            neg_d  = res_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.ZERO      = zero_q;
    assign bus.NEG       = neg_q;
    assign bus.CARRY     = carry_q;
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected result, flags and
// latency pushed at issue, popped when out_valid is seen.
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: flags ordered {ZERO, NEG, CARRY, OVF}.
    function automatic exp_t model(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic s);
        exp_t       e;
        logic [W:0] w;
        int         sa, sbv, sr, n, prod, lim;
        logic       c, o;
        sa   = $signed(a);
        sbv  = $signed(b);
        lim  = 1 << (W - 1);
        n    = (int'(b) >= W) ? W : int'(b);
        c    = 1'b0;
        o    = 1'b0;
        e.lat = 1;
        case (op)
            3'd0: begin
                prod  = int'(a) * int'(b);
                e.res = prod[W-1:0];
                e.lat = W + 1;
            end
            3'd1: begin
                w     = {1'b0, a} + {1'b0, b};
                e.res = w[W-1:0];
                c     = w[W];
                sr    = sa + sbv;
                o     = s && (sr >= lim || sr < -lim);
            end
            3'd2: begin
                e.res = a - b;
                c     = (a >= b);
                sr    = sa - sbv;
                o     = s && (sr >= lim || sr < -lim);
            end
            3'd3: e.res = a & b;
            3'd4: e.res = a | b;
            3'd5: begin
                e.res = a << b;
                e.lat = n + 1;
            end
            3'd6: begin
                e.res = a >> b;
                e.lat = n + 1;
            end
            default: begin
                e.res = $signed(a) >>> b;
                e.lat = n + 1;
            end
        endcase
        e.fl = {(e.res == '0), e.res[W-1], c, o};
        return e;
    endfunction

    task automatic send_op(input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.operation = op;
        bus.op1       = a;
        bus.op2       = b;
        bus.is_signed = s;
        bus.in_valid  = 1'b1;
        sb_q.push_back(model(op, a, b, s));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.op1       = W'($urandom);
        bus.op2       = W'($urandom);
        bus.operation = 3'($urandom);
        bus.is_signed = 1'($urandom);
    endtask

    task automatic wait_out(output logic [W-1:0] r, output logic [3:0] f,
                            output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        r = bus.result;
        f = {bus.ZERO, bus.NEG, bus.CARRY, bus.OVF};
    endtask

    task automatic release_out;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.operation = 3'd1;
        bus.op1       = 8'h5A;
        bus.op2       = 8'hA5;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
        n_chk++;
        if (bus.result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 00", bus.result);
        end
        n_chk++;
        if ({bus.ZERO, bus.NEG, bus.CARRY, bus.OVF} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.ZERO, bus.NEG, bus.CARRY, bus.OVF});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        sb_q.delete();
    endtask

    task automatic run_table(input string name, input logic [2:0] ops[],
                             input logic [W-1:0] as[],
                             input logic [W-1:0] bs[], input logic ss[]);
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        exp_t         e;
        foreach (ops[i]) begin
            send_op(ops[i], as[i], bs[i], ss[i]);
            wait_out(r, f, lat);
            e = sb_q.pop_front();
            n_chk++;
            if (r !== e.res) begin
                n_fail++;
                $display("FAIL %s[%0d] result: got %h want %h",
                         name, i, r, e.res);
            end
            n_chk++;
            if (f !== e.fl) begin
                n_fail++;
                $display("FAIL %s[%0d] flags ZNCV: got %b want %b",
                         name, i, f, e.fl);
            end
            n_chk++;
            if (lat != e.lat) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: got %0d want %0d",
                         name, i, lat, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_add_sub;
        run_table("addsub",
                  '{3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4},
                  '{8'h7F, 8'h05, 8'hFF, 8'h03, 8'h80, 8'hF0, 8'h0F},
                  '{8'h01, 8'h05, 8'h01, 8'h05, 8'h01, 8'h3C, 8'h30},
                  '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_shifts;
        run_table("shift",
                  '{3'd5, 3'd7, 3'd6, 3'd6, 3'd7, 3'd5, 3'd7},
                  '{8'h81, 8'h80, 8'hF0, 8'hF0, 8'h40, 8'h01, 8'h7F},
                  '{8'd3, 8'd9, 8'd0, 8'd4, 8'd2, 8'd8, 8'd200},
                  '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_mul;
        run_table("mul",
                  '{3'd0, 3'd0, 3'd0, 3'd0},
                  '{8'h0D, 8'hFF, 8'h00, 8'h12},
                  '{8'h0B, 8'hFF, 8'h55, 8'h34},
                  '{1'b0, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_backpressure;
        logic [W-1:0] r0;
        logic [3:0]   f0;
        int           lat;
        exp_t         e;
        send_op(3'd1, 8'h30, 8'h0C, 1'b0);
        wait_out(r0, f0, lat);
        e = sb_q.pop_front();
        n_chk++;
        if (r0 !== e.res || f0 !== e.fl) begin
            n_fail++;
            $display("FAIL bp_first: got %h/%b want %h/%b",
                     r0, f0, e.res, e.fl);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid  = (i == 1);
            bus.operation = 3'd3;
            bus.op1       = 8'h00;
            bus.op2       = 8'h00;
            n_chk++;
            if (bus.result !== r0 ||
                {bus.ZERO, bus.NEG, bus.CARRY, bus.OVF} !== f0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h/%b want %h/%b", i,
                         bus.result, {bus.ZERO, bus.NEG, bus.CARRY, bus.OVF},
                         r0, f0);
            end
            n_chk++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hs[%0d]: in_ready=%b out_valid=%b want 0/1",
                         i, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        release_out();
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
        run_table("bp_next", '{3'd2}, '{8'h10}, '{8'h20}, '{1'b1});
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        send_op(3'd0, 8'h0D, 8'h0B, 1'b0);
        void'(sb_q.pop_back());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.result !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: rdy=%b vld=%b res=%h want 1/0/00",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_out: out_valid seen %0d cycles want 0",
                     seen);
        end
        run_table("midrst_next", '{3'd0, 3'd1},
                  '{8'h0D, 8'h7F}, '{8'h0B, 8'h01}, '{1'b0, 1'b1});
    endtask

    task automatic test_random;
        logic [2:0]   ops[16];
        logic [W-1:0] as[16];
        logic [W-1:0] bs[16];
        logic         ss[16];
        for (int i = 0; i < 16; i++) begin
            ops[i] = 3'($urandom);
            as[i]  = W'($urandom);
            bs[i]  = (ops[i] >= 3'd5) ? W'($urandom_range(0, 10))
                                      : W'($urandom);
            ss[i]  = 1'($urandom);
        end
        run_table("random", ops, as, bs, ss);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.operation = '0;
        bus.is_signed = 1'b0;
        test_reset();
        test_add_sub();
        test_shifts();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
